// File: rtl/matmul_sequencer_if.sv
// matmul_sequencer_if
// Groups the control, matrix-memory and uart_tx signals of matmul_sequencer.
//   start/size        : begin-multiply pulse and matrix dimension N from control unit
//   a_addr/a_rdata    : A memory read port (data valid 1 cycle after address)
//   b_addr/b_rdata    : B memory read port (data valid 1 cycle after address)
//   tx_data/tx_start  : byte and one-cycle transmit request to uart_tx
//   tx_busy           : uart_tx busy
//   busy/done/err     : sequencer status
// Modport master is the sequencer side; slave is the surrounding environment.
interface matmul_sequencer_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic              start;
   logic [2:0]        size;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_rdata;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_rdata;
   logic [DATA_W-1:0] tx_data;
   logic              tx_start;
   logic              tx_busy;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      input  start, size, a_rdata, b_rdata, tx_busy,
      output a_addr, b_addr, tx_data, tx_start, busy, done, err
   );

   modport slave (
      output start, size, a_rdata, b_rdata, tx_busy,
      input  a_addr, b_addr, tx_data, tx_start, busy, done, err
   );
endinterface

// File: rtl/matmul_sequencer.sv
// matmul_sequencer
// Sequences one NxN (N = 1..4) matrix multiply over the A/B memories and
// streams each result element to uart_tx as ACC_W/DATA_W bytes, MSB first,
// in row-major order.
// Ports:
//   clk : bclk-domain clock, rising edge
//   rst : synchronous active-high reset
//   bus : matmul_sequencer_if master modport (control, memory, uart, status)
module matmul_sequencer #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int ACC_W  = 24
) (
   input  logic                clk,
   input  logic                rst,
   matmul_sequencer_if.master  bus
);

   localparam int NBYTES = ACC_W / DATA_W;
   localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD_ADDR = 3'd1;
   localparam logic [2:0] S_RD_DATA = 3'd2;
   localparam logic [2:0] S_TX_LOAD = 3'd3;
   localparam logic [2:0] S_TX_REQ  = 3'd4;
   localparam logic [2:0] S_TX_ACK  = 3'd5;
   localparam logic [2:0] S_TX_WAIT = 3'd6;
   localparam logic [2:0] S_DONE    = 3'd7;

   logic [2:0]          state;
   logic [2:0]          n;
   logic [2:0]          i;
   logic [2:0]          j;
   logic [2:0]          k;
   logic [ACC_W-1:0]    acc;
   logic [BIDX_W-1:0]   bidx;
   logic [ADDR_W-1:0]   row_base;   // i*N, advanced by N per finished row
   logic [ADDR_W-1:0]   a_addr;
   logic [ADDR_W-1:0]   b_addr;
   logic [DATA_W-1:0]   tx_data;
   logic                tx_start;
   logic                busy;
   logic                done;
   logic                err;
   logic [2*DATA_W-1:0] prod;

   assign prod         = bus.a_rdata * bus.b_rdata;
   assign bus.a_addr   = a_addr;
   assign bus.b_addr   = b_addr;
   assign bus.tx_data  = tx_data;
   assign bus.tx_start = tx_start;
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.err      = err;

   // Addresses are loaded on the transition into RD_ADDR so they are stable
   // for the whole RD_ADDR cycle; the registered memories then return data
   // during RD_DATA, where it is accumulated.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         n        <= '0;
         i        <= '0;
         j        <= '0;
         k        <= '0;
         acc      <= '0;
         bidx     <= '0;
         row_base <= '0;
         a_addr   <= '0;
         b_addr   <= '0;
         tx_data  <= '0;
         tx_start <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.size == 3'd0 || bus.size > 3'd4) begin
                     err <= 1'b1;
                  end else begin
                     n        <= bus.size;
                     i        <= '0;
                     j        <= '0;
                     k        <= '0;
                     acc      <= '0;
                     row_base <= '0;
                     a_addr   <= '0;
                     b_addr   <= '0;
                     busy     <= 1'b1;
                     state    <= S_RD_ADDR;
                  end
               end
            end
            S_RD_ADDR: state <= S_RD_DATA;
            S_RD_DATA: begin
               acc <= acc + ACC_W'(prod);
               if (k == n - 3'd1) begin
                  state <= S_TX_LOAD;
               end else begin
                  // next k: A steps one column, B steps one row
                  k      <= k + 3'd1;
                  a_addr <= a_addr + ADDR_W'(1);
                  b_addr <= b_addr + ADDR_W'(n);
                  state  <= S_RD_ADDR;
               end
            end
            S_TX_LOAD: begin
               bidx  <= BIDX_W'(NBYTES - 1);
               state <= S_TX_REQ;
            end
            S_TX_REQ: begin
               if (!bus.tx_busy) begin
                  tx_data  <= acc[DATA_W*bidx +: DATA_W];
                  tx_start <= 1'b1;
                  state    <= S_TX_ACK;
               end
            end
            S_TX_ACK: begin
               if (bus.tx_busy) state <= S_TX_WAIT;
            end
            S_TX_WAIT: begin
               if (!bus.tx_busy) begin
                  if (bidx != '0) begin
                     bidx  <= bidx - BIDX_W'(1);
                     state <= S_TX_REQ;
                  end else begin
                     acc <= '0;
                     k   <= '0;
                     if (j < n - 3'd1) begin
                        j      <= j + 3'd1;
                        a_addr <= row_base;
                        b_addr <= ADDR_W'(j) + ADDR_W'(1);
                     end else begin
                        j        <= '0;
                        i        <= i + 3'd1;
                        row_base <= row_base + ADDR_W'(n);
                        a_addr   <= row_base + ADDR_W'(n);
                        b_addr   <= '0;
                     end
                     if (i == n - 3'd1 && j == n - 3'd1) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                     end else begin
                        state <= S_RD_ADDR;
                     end
                  end
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer
// Self-checking bench: registered A/B memories, a uart_tx stand-in that stays
// busy for ulen cycles after each request, table-driven cases, directed
// multi-cycle sequences and randomized runs against a matrix-product model.
module tb_matmul_sequencer;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int ACC_W  = 24;

   typedef struct {
      int           n;
      logic [127:0] a;
      logic [127:0] b;
      logic         exp_err;
      logic [23:0]  exp_first;
      logic [23:0]  exp_last;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   matmul_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

   matmul_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] mem_a [16];
   logic [7:0] mem_b [16];
   int         ucnt = 0;
   int         ulen = 10;
   logic       force_busy = 1'b0;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] got [$];
   logic [7:0] exp_q [$];
   int         done_cnt = 0;
   int         err_cnt = 0;
   logic       busy_seen = 1'b0;

   always @(posedge clk) begin
      bus.a_rdata <= mem_a[bus.a_addr];
      bus.b_rdata <= mem_b[bus.b_addr];
   end

   always @(posedge clk) begin
      if (bus.tx_start) ucnt <= ulen;
      else if (ucnt > 0) ucnt <= ucnt - 1;
   end
   assign bus.tx_busy = force_busy || (ucnt != 0);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Output monitor, sampled 1 time unit after the active edge.
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         if (bus.tx_start) begin
            got.push_back(bus.tx_data);
            check("tx_start_while_busy", {31'd0, bus.tx_busy}, 32'd0);
         end
         if (bus.done) done_cnt++;
         if (bus.err)  err_cnt++;
         if (bus.busy) busy_seen = 1'b1;
      end
   end

   // C = A*B, row-major, 3 bytes per element MSB first
   task automatic build_expected(input int n);
      exp_q.delete();
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++) begin
            logic [23:0] s;
            s = '0;
            for (int t = 0; t < n; t++)
               s = s + 24'(mem_a[r*n+t]) * 24'(mem_b[t*n+c]);
            exp_q.push_back(s[23:16]);
            exp_q.push_back(s[15:8]);
            exp_q.push_back(s[7:0]);
         end
   endtask

   task automatic load_mem(input logic [127:0] a, input logic [127:0] b);
      for (int x = 0; x < 16; x++) begin
         mem_a[x] = a[8*x +: 8];
         mem_b[x] = b[8*x +: 8];
      end
   endtask

   task automatic wait_uart_idle();
      for (int c = 0; c < 200 && bus.tx_busy; c++) @(negedge clk);
      @(negedge clk);
   endtask

   task automatic clear_mon();
      got.delete();
      done_cnt  = 0;
      err_cnt   = 0;
      busy_seen = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      logic to;
      to = 1'b1;
      for (int c = 0; c < budget; c++) begin
         if (done_cnt != 0) begin to = 1'b0; break; end
         @(negedge clk);
      end
      check("done_timeout", {31'd0, to}, 32'd0);
   endtask

   task automatic compare_bytes(input string tag);
      check({tag, "_nbytes"}, got.size(), exp_q.size());
      for (int x = 0; x < exp_q.size() && x < got.size(); x++)
         check({tag, "_byte"}, {24'd0, got[x]}, {24'd0, exp_q[x]});
   endtask

   // Full operation: start pulse, optional tx_busy hold for `hold` cycles and
   // an extra start pulse at cycle `extra_at`, then byte stream vs model.
   task automatic run_op(input int n, input logic [127:0] a, input logic [127:0] b,
                         input int hold, input int extra_at);
      wait_uart_idle();
      load_mem(a, b);
      clear_mon();
      @(negedge clk);
      bus.start  = 1'b1;
      bus.size   = 3'(n);
      force_busy = (hold > 0);
      @(negedge clk);
      bus.start = 1'b0;
      if (n < 1 || n > 4) begin
         force_busy = 1'b0;
         repeat (5) @(negedge clk);
         check("illegal_busy", {31'd0, busy_seen}, 32'd0);
         check("illegal_done", done_cnt, 0);
         check("illegal_tx", got.size(), 0);
         return;
      end
      build_expected(n);
      begin
         logic to;
         to = 1'b1;
         for (int c = 0; c < 20000; c++) begin
            if (done_cnt != 0) begin to = 1'b0; break; end
            if (c == hold) force_busy = 1'b0;
            if (c == extra_at) begin bus.start = 1'b1; bus.size = 3'd3; end
            else bus.start = 1'b0;
            @(negedge clk);
         end
         bus.start  = 1'b0;
         force_busy = 1'b0;
         check("op_timeout", {31'd0, to}, 32'd0);
      end
      compare_bytes("op");
      check("op_done_cnt", done_cnt, 1);
      repeat (2) @(negedge clk);
      check("op_busy_after", {31'd0, bus.busy}, 32'd0);
   endtask

   vec_t vecs [6];

   initial begin
      bus.start = 1'b0;
      bus.size  = 3'd0;
      for (int x = 0; x < 16; x++) begin mem_a[x] = '0; mem_b[x] = '0; end

      vecs[0] = '{1, 128'h03, 128'h05, 1'b0, 24'h00000F, 24'h00000F};
      vecs[1] = '{2, 128'h04030201, 128'h08070605, 1'b0, 24'h000013, 24'h000032};
      vecs[2] = '{4, {16{8'hFF}}, {16{8'hFF}}, 1'b0, 24'h03F804, 24'h03F804};
      vecs[3] = '{0, 128'h0, 128'h0, 1'b1, 24'h0, 24'h0};
      vecs[4] = '{5, 128'h0, 128'h0, 1'b1, 24'h0, 24'h0};
      vecs[5] = '{3, 128'h090807060504030201, 128'h010000000100000001, 1'b0,
                  24'h000001, 24'h000009};

      // reset state
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {bus.a_addr, bus.b_addr, bus.tx_data, bus.tx_start, bus.busy, bus.done, bus.err},
            32'd0);
      rst = 1'b0;
      @(negedge clk);

      // table-driven cases
      for (int v = 0; v < 6; v++) begin
         run_op(vecs[v].n, vecs[v].a, vecs[v].b, 0, -1);
         check("tbl_err", err_cnt, vecs[v].exp_err ? 1 : 0);
         if (!vecs[v].exp_err) begin
            check("tbl_pulses", got.size(), 3 * vecs[v].n * vecs[v].n);
            if (got.size() >= 3) begin
               check("tbl_first", {8'd0, got[0], got[1], got[2]}, {8'd0, vecs[v].exp_first});
               check("tbl_last", {8'd0, got[got.size()-3], got[got.size()-2], got[got.size()-1]},
                     {8'd0, vecs[v].exp_last});
            end
         end
      end

      // N=1 latency: RD_ADDR, RD_DATA, TX_LOAD, TX_REQ, then tx_start
      wait_uart_idle();
      load_mem(128'h03, 128'h05);
      clear_mon();
      @(negedge clk);
      bus.start = 1'b1;
      bus.size  = 3'd1;
      begin
         int lat;
         lat = 0;
         for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.tx_start) begin lat = c; break; end
         end
         check("first_tx_latency", lat, 5);
      end
      build_expected(1);
      wait_done(500);
      compare_bytes("lat");

      // N=2 address sequence for C(0,0)
      wait_uart_idle();
      load_mem(128'h04030201, 128'h08070605);
      clear_mon();
      @(negedge clk);
      bus.start = 1'b1;
      bus.size  = 3'd2;
      @(negedge clk);
      bus.start = 1'b0;
      check("addr_k0", {24'd0, bus.a_addr, bus.b_addr}, {24'd0, 4'd0, 4'd0});
      repeat (2) @(negedge clk);
      check("addr_k1", {24'd0, bus.a_addr, bus.b_addr}, {24'd0, 4'd1, 4'd2});
      build_expected(2);
      wait_done(2000);
      compare_bytes("addr");

      // extra start while busy plus tx_busy held for 50 cycles
      run_op(2, 128'h04030201, 128'h08070605, 50, 2);
      check("extra_start_err", err_cnt, 0);

      // reset during TX_WAIT of the 2nd byte
      wait_uart_idle();
      load_mem(128'h04030201, 128'h08070605);
      clear_mon();
      @(negedge clk);
      bus.start = 1'b1;
      bus.size  = 3'd2;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 0; c < 500 && got.size() < 2; c++) @(negedge clk);
      check("rst_seq_two_bytes", got.size(), 2);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_outputs",
            {bus.a_addr, bus.b_addr, bus.tx_data, bus.tx_start, bus.busy, bus.done, bus.err},
            32'd0);
      rst = 1'b0;
      clear_mon();
      repeat (30) @(negedge clk);
      check("rst_no_more_tx", got.size(), 0);
      check("rst_no_done", done_cnt, 0);
      run_op(1, 128'h03, 128'h05, 0, -1);
      if (got.size() >= 3)
         check("rst_fresh_result", {8'd0, got[0], got[1], got[2]}, 32'h00000F);

      // randomized runs
      for (int r = 0; r < 6; r++) begin
         logic [127:0] ra, rb;
         int rn;
         rn   = $urandom_range(1, 4);
         ulen = $urandom_range(1, 6);
         for (int x = 0; x < 4; x++) begin
            ra[32*x +: 32] = $urandom;
            rb[32*x +: 32] = $urandom;
         end
         run_op(rn, ra, rb, $urandom_range(0, 5), $urandom_range(0, 30));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
Controller that sequences one NxN matrix multiply (N = 1..4) over the A and B matrix memories, once the control unit has finished loading them. It reads A and B element by element and accumulates each result element. Each result element is streamed to the UART transmitter as 3 bytes, MSB first. It sits between the matrix memories, the control unit and uart_tx, in the bclk domain.

Parameters:
DATA_W, 8, element width of A/B and UART byte width
ADDR_W, 4, matrix memory address width (16 entries, row-major, addr = row*N + col)
ACC_W, 24, accumulator width; results transmitted as ACC_W/8 bytes

Ports:
clk  input  1  system clock (bclk domain); all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse from control unit: begin multiply
size  input  3  matrix dimension N; sampled on accepted start
a_addr  output  ADDR_W  A memory read address
a_rdata  input  DATA_W  A memory read data, valid 1 cycle after a_addr
b_addr  output  ADDR_W  B memory read address
b_rdata  input  DATA_W  B memory read data, valid 1 cycle after b_addr
tx_data  output  DATA_W  byte to uart_tx
tx_start  output  1  one-cycle transmit request to uart_tx
tx_busy  input  1  uart_tx busy
busy  output  1  high from accepted start until DONE exits
done  output  1  one-cycle pulse after last byte's tx_busy falls
err  output  1  one-cycle pulse: start with illegal size

Behaviour:
- Reset (synchronous, rst high at clk edge): state IDLE. a_addr=0, b_addr=0, tx_data=0, tx_start=0, busy=0, done=0, err=0. Accumulator and i/j/k counters cleared. rst mid-operation aborts immediately; no further tx_start is issued.
- Start handling:
  - start is accepted only in IDLE; start while busy is ignored.
  - size 0 or >4: err=1 for one cycle, remain IDLE, busy stays 0.
  - Legal size: latch N, clear i=j=k=0 and acc=0, busy=1 next cycle.
- States: IDLE, RD_ADDR, RD_DATA, TX_LOAD, TX_REQ, TX_ACK, TX_WAIT, DONE.
- RD_ADDR:
  - Drive a_addr = i*N + k and b_addr = k*N + j, computed by running offsets, no multiplier.
  - Go to RD_DATA.
- RD_DATA:
  - acc <= acc + a_rdata*b_rdata (unsigned, zero-extended to ACC_W).
  - If k == N-1, go to TX_LOAD; else k++ and go to RD_ADDR.
  - Each result element costs exactly 2N cycles of reading.
- TX_LOAD: byte index b=2; go to TX_REQ.
- TX_REQ:
  - Wait while tx_busy=1.
  - When tx_busy=0: tx_data = acc[8b+7:8b], tx_start=1 for exactly one cycle, go to TX_ACK.
- TX_ACK:
  - Wait for tx_busy=1, then go to TX_WAIT.
  - tx_data is held stable from TX_REQ until TX_WAIT exits.
- TX_WAIT:
  - Wait for tx_busy=0.
  - If b>0: b--, go to TX_REQ.
  - Else: clear acc and k. If j<N-1, j++; else j=0 and i++.
  - If the element just sent was (N-1,N-1), go to DONE; else go to RD_ADDR.
- DONE: done=1 for one cycle, busy=0, return to IDLE. A start in that same cycle is ignored.
- Output order: row-major C(0,0), C(0,1), ...; 3 bytes per element, 3*N*N tx_start pulses total.
- Width: max result 4*255*255 = 260100 = 0x03F804 fits in 24 bits; no overflow handling required.
- a_addr/b_addr hold their last value outside RD_ADDR.
- tx_start is never asserted while tx_busy=1 or outside TX_REQ.

Test Plan:
- N=1, A=[3], B=[5], tx_busy modeled as 10 cycles after tx_start -> bytes 00 00 0F, then done pulse. First tx_start occurs 2 reading cycles + TX_LOAD after start.
- N=2, A=[1 2;3 4], B=[5 6;7 8] -> bytes 00 00 13, 00 00 16, 00 00 2B, 00 00 32. Address sequence for C(0,0): a=0,b=0 then a=1,b=2.
- N=4, all A and B entries 255 -> 16 repetitions of 03 F8 04, 48 tx_start pulses, no accumulator carry loss.
- size=0, then size=5 -> err pulses once each; busy, tx_start and done stay 0.
- start pulsed again mid-computation, and tx_busy held high 50 cycles before the first request -> extra start ignored, tx_start delayed until tx_busy=0, output unchanged.
- rst asserted during TX_WAIT of the 2nd byte -> next edge all outputs 0, state IDLE. A fresh start with N=1 then produces a correct result.
